hs_rr_arbiter: RTL and testbench



---
 rtl/hs_rr_arbiter.sv | 111 +++++++++++
 tb/tb_hs_rr_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter merging NUM_REQ valid/ready masters onto one registered output stage.
// Defining ARB_STALL_CNT_EN adds a saturating stall_cnt output (cycles with m_valid=1 and m_ready=0).
module hs_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [IDX_W-1:0]          m_src
`ifdef ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t              state_r;
    logic [IDX_W-1:0]    last_ptr_r;
    logic [IDX_W-1:0]    gnt_s;
    logic [IDX_W-1:0]    cand_s;
    logic                found_s;
    logic                can_load_s;
    logic                load_s;
    logic [DATA_W-1:0]   gnt_data_s;

    // Load is possible when the stage is empty or drains on this same edge.
    always_comb begin
        can_load_s = (state_r == ST_EMPTY) | ((state_r == ST_FULL) & m_ready);
        load_s     = can_load_s & (|s_valid) & ~reset;
    end

    // Rotating priority search: first requester after the last grant wins.
    always_comb begin
        gnt_s   = {IDX_W{1'b0}};
        cand_s  = {IDX_W{1'b0}};
        found_s = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_s  = IDX_W'((int'(last_ptr_r) + k) % NUM_REQ);
            gnt_s   = (s_valid[cand_s] & ~found_s) ? cand_s : gnt_s;
            found_s = found_s | s_valid[cand_s];
        end
    end

    // Winner data mux and one-hot ready generation.
    always_comb begin
        gnt_data_s = {DATA_W{1'b0}};
        s_ready    = {NUM_REQ{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            gnt_data_s = (gnt_s == IDX_W'(i)) ? s_data[i*DATA_W +: DATA_W] : gnt_data_s;
            s_ready[i] = load_s & (gnt_s == IDX_W'(i));
        end
    end

    // Output stage and grant pointer; a capture may coincide with a downstream accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_EMPTY;
            m_valid    <= 1'b0;
            m_data     <= {DATA_W{1'b0}};
            m_src      <= {IDX_W{1'b0}};
            last_ptr_r <= IDX_W'(NUM_REQ - 1);
        end else if (load_s) begin
            state_r    <= ST_FULL;
            m_valid    <= 1'b1;
            m_data     <= gnt_data_s;
            m_src      <= gnt_s;
            last_ptr_r <= gnt_s;
        end else if ((state_r == ST_FULL) & m_ready) begin
            state_r    <= ST_EMPTY;
            m_valid    <= 1'b0;
            m_data     <= m_data;
            m_src      <= m_src;
            last_ptr_r <= last_ptr_r;
        end else begin
            state_r    <= state_r;
            m_valid    <= m_valid;
            m_data     <= m_data;
            m_src      <= m_src;
            last_ptr_r <= last_ptr_r;
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [15:0] stall_cnt_r;

    assign stall_cnt = stall_cnt_r;

    // Saturating count of cycles where the downstream back-pressures a held word.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 16'h0000;
        end else if (m_valid & ~m_ready & (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Self-checking bench for hs_rr_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_hs_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 32;
    localparam int IDX_W   = 2;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ*DATA_W-1:0] s_data = '0;
    logic [NUM_REQ-1:0]        s_valid = '0;
    logic [NUM_REQ-1:0]        s_ready;
    logic [DATA_W-1:0]         m_data;
    logic                      m_valid;
    logic                      m_ready = 1'b1;
    logic [IDX_W-1:0]          m_src;
`ifdef ARB_STALL_CNT_EN
    logic [15:0]               stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    bit          mdl_valid = 1'b0;
    logic [31:0] mdl_data  = 32'h0;
    int          mdl_src   = 0;
    int          mdl_last  = NUM_REQ - 1;
    int          mdl_stall = 0;

    hs_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_src(m_src)
`ifdef ARB_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int mdl_grant(input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(mdl_last + k) % NUM_REQ]) return (mdl_last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic logic [NUM_REQ-1:0] mdl_ready();
        logic [NUM_REQ-1:0] r;
        int g;
        r = '0;
        g = mdl_grant(s_valid);
        if (!reset && g >= 0 && (!mdl_valid || m_ready)) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin : mdl_p
        int g;
        if (reset) begin
            mdl_valid = 1'b0; mdl_data = 32'h0; mdl_src = 0; mdl_last = NUM_REQ - 1; mdl_stall = 0;
        end else begin
            if (mdl_valid && !m_ready && mdl_stall < 65535) mdl_stall++;
            g = mdl_grant(s_valid);
            if ((!mdl_valid || m_ready) && g >= 0) begin
                mdl_valid = 1'b1; mdl_data = s_data[g*DATA_W +: DATA_W]; mdl_src = g; mdl_last = g;
            end else if (mdl_valid && m_ready) begin
                mdl_valid = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; s_valid = '0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; s_valid = '0; m_ready = 1'b1;
        repeat (10) @(negedge clk);
        s_valid = 4'hF; #1;
        checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_sready_forced: got %b exp 0000", s_ready); end
        s_valid = '0;
        @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rst_mvalid: got %b exp 0", m_valid); end
            checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL rst_sready: got %b exp 0000", s_ready); end
            checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL rst_msrc: got %0d exp 0", m_src); end
            checks++; if (m_data !== 32'h0) begin errors++; $display("FAIL rst_mdata: got %h exp 0", m_data); end
            @(negedge clk);
        end
    endtask

    task automatic test_single();
        s_data[31:0] = 32'h20220503; s_valid = 4'b0001; m_ready = 1'b1; #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL single_sready: got %b exp 0001", s_ready); end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (m_data !== 32'h20220503) begin errors++; $display("FAIL single_mdata: got %h exp 20220503", m_data); end
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_mvalid: got %b exp 1", m_valid); end
        checks++; if (m_src !== 2'd0) begin errors++; $display("FAIL single_msrc: got %0d exp 0", m_src); end
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL single_drop: got %b exp 0", m_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) s_data[i*DATA_W +: DATA_W] = 32'hA0 + 32'(i);
        s_valid = 4'hF; m_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks++; if (s_ready !== (4'b0001 << (k % 4))) begin errors++; $display("FAIL rr_sready[%0d]: got %b exp %b", k, s_ready, 4'b0001 << (k % 4)); end
            if (k > 0) begin
                checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rr_mvalid[%0d]: got %b exp 1", k, m_valid); end
                checks++; if (m_src !== IDX_W'((k - 1) % 4)) begin errors++; $display("FAIL rr_msrc[%0d]: got %0d exp %0d", k, m_src, (k - 1) % 4); end
                checks++; if (m_data !== 32'hA0 + 32'((k - 1) % 4)) begin errors++; $display("FAIL rr_mdata[%0d]: got %h exp %h", k, m_data, 32'hA0 + 32'((k - 1) % 4)); end
            end
            @(negedge clk);
        end
        s_valid = '0; #1;
        checks++; if (m_src !== 2'd1 || m_data !== 32'hA1) begin errors++; $display("FAIL rr_last: got src %0d data %h exp 1 a1", m_src, m_data); end
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b exp 0", m_valid); end
    endtask

    task automatic test_stall();
        do_reset();
        s_data[2*DATA_W +: DATA_W] = 32'h10000006; s_data[31:0] = 32'h0000C0DE;
        s_valid = 4'b0100; m_ready = 1'b0; #1;
        checks++; if (s_ready !== 4'b0100) begin errors++; $display("FAIL stall_accept: got %b exp 0100", s_ready); end
        @(negedge clk); s_valid = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++; if (m_valid !== 1'b1 || m_data !== 32'h10000006 || m_src !== 2'd2) begin
                errors++; $display("FAIL stall_hold[%0d]: got v%b %h src %0d exp v1 10000006 src 2", c, m_valid, m_data, m_src); end
            checks++; if (s_ready !== 4'b0000) begin errors++; $display("FAIL stall_sready[%0d]: got %b exp 0000", c, s_ready); end
            @(negedge clk);
        end
`ifdef ARB_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd5) begin errors++; $display("FAIL stall_cnt: got %0d exp 5", stall_cnt); end
`endif
        m_ready = 1'b1; #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL stall_b2b_sready: got %b exp 0001", s_ready); end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (m_valid !== 1'b1 || m_src !== 2'd0 || m_data !== 32'h0000C0DE) begin
            errors++; $display("FAIL stall_b2b_word: got v%b src %0d %h exp v1 src 0 0000c0de", m_valid, m_src, m_data); end
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL stall_drain: got %b exp 0", m_valid); end
    endtask

    task automatic test_priority();
        do_reset();
        s_data[1*DATA_W +: DATA_W] = 32'h11111111; s_data[3*DATA_W +: DATA_W] = 32'h33333333;
        s_valid = 4'b0010; m_ready = 1'b1; #1;
        checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL prio_first: got %b exp 0010", s_ready); end
        @(negedge clk); s_valid = 4'b1010; #1;
        checks++; if (s_ready !== 4'b1000) begin errors++; $display("FAIL prio_p3_wins: got %b exp 1000", s_ready); end
        @(negedge clk); s_valid = 4'b0010; #1;
        checks++; if (s_ready !== 4'b0010) begin errors++; $display("FAIL prio_p1_next: got %b exp 0010", s_ready); end
        checks++; if (m_src !== 2'd3 || m_data !== 32'h33333333) begin errors++; $display("FAIL prio_word3: got src %0d %h exp 3 33333333", m_src, m_data); end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (m_src !== 2'd1 || m_data !== 32'h11111111) begin errors++; $display("FAIL prio_word1: got src %0d %h exp 1 11111111", m_src, m_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        s_data[2*DATA_W +: DATA_W] = 32'h22222222; s_data[31:0] = 32'h0BAD0000;
        s_valid = 4'b0100; m_ready = 1'b0;
        @(negedge clk); s_valid = '0; #1;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL rmid_full: got %b exp 1", m_valid); end
        reset = 1'b1;
        @(negedge clk); #1;
        checks++; if (m_valid !== 1'b0 || m_src !== 2'd0 || m_data !== 32'h0) begin
            errors++; $display("FAIL rmid_cleared: got v%b src %0d %h exp v0 src 0 0", m_valid, m_src, m_data); end
`ifdef ARB_STALL_CNT_EN
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL rmid_stall: got %0d exp 0", stall_cnt); end
`endif
        reset = 1'b0; s_valid = 4'hF; m_ready = 1'b1; #1;
        checks++; if (s_ready !== 4'b0001) begin errors++; $display("FAIL rmid_port0_first: got %b exp 0001", s_ready); end
        @(negedge clk); s_valid = '0; #1;
        checks++; if (m_src !== 2'd0 || m_data !== 32'h0BAD0000) begin errors++; $display("FAIL rmid_word: got src %0d %h exp 0 0bad0000", m_src, m_data); end
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [NUM_REQ-1:0] acc;
        logic [NUM_REQ-1:0] exp_r;
        acc = '0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            checks++; if (m_valid !== mdl_valid) begin errors++; $display("FAIL rnd_mvalid[%0d]: got %b exp %b", n, m_valid, mdl_valid); end
            checks++; if (m_data !== mdl_data || m_src !== IDX_W'(mdl_src)) begin
                errors++; $display("FAIL rnd_word[%0d]: got src %0d %h exp src %0d %h", n, m_src, m_data, mdl_src, mdl_data); end
`ifdef ARB_STALL_CNT_EN
            checks++; if (stall_cnt !== 16'(mdl_stall)) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d exp %0d", n, stall_cnt, mdl_stall); end
`endif
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!s_valid[i] || acc[i]) begin
                    s_valid[i] = ($urandom_range(0, 2) != 0);
                    s_data[i*DATA_W +: DATA_W] = $urandom;
                end
            end
            m_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_r = mdl_ready();
            checks++; if (s_ready !== exp_r) begin errors++; $display("FAIL rnd_sready[%0d]: got %b exp %b", n, s_ready, exp_r); end
            acc = exp_r;
        end
        @(negedge clk); s_valid = '0; m_ready = 1'b1;
        @(negedge clk);
    endtask

`ifdef ARB_STALL_CNT_EN
    task automatic test_stall_sat();
        do_reset();
        s_valid = 4'b0001; m_ready = 1'b0;
        @(negedge clk); s_valid = '0;
        repeat (70000) @(negedge clk);
        checks++; if (stall_cnt !== 16'hFFFF) begin errors++; $display("FAIL stall_sat: got %h exp ffff", stall_cnt); end
        m_ready = 1'b1;
        @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_priority();
        test_reset_mid();
        test_random();
`ifdef ARB_STALL_CNT_EN
        test_stall_sat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
